param_computer: RTL and testbench
=================================

# param_computer

Parametrised multicycle accumulator-free register computer: our 4-bit fixed-format single-cycle computer generalised in data width, register count and memory depths. It adds a fetch/execute state machine, an internal loadable program memory, a data memory, conditional branches and halt. It is the top-level CPU for the lab board and drives debug outputs for the seven-segment/LED harness.

## Interface
- DW, 8, data/register width (≥4)
- RA, 2, register-address bits; NREG = 2^RA registers
- IMW, 5, program-memory address bits (PC width)
- DMW, 4, data-memory address bits; address = low DMW bits of Ra
- Instruction width IW = 4 + 3*RA + DW: {OP[3:0], DA, AA, BA, IMM[DW-1:0]}, OP in MSBs
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- RUN  in  1  leave IDLE and start executing at PC 0
- PROG_WE  in  1  program-memory write strobe
- PROG_ADDR  in  IMW  program-memory write address
- PROG_DATA  in  IW  program word
- DBG_SEL  in  RA  register selected for DBG_REG
- DBG_REG  out  DW  combinational read of register DBG_SEL
- PC  out  IMW  program counter
- IR  out  IW  instruction register
- STATE  out  3  IDLE=0, FETCH=1, EXEC=2, MEM=3, HALT=4
- HALTED  out  1  high in HALT
- DATA_OUT  out  DW  last value read from data memory (registered)
- MEM_WE  out  1  high for the cycle a store is committed
- STEP  in  1  present only with PARAM_COMPUTER_STEP_EN

## Operation
- Opcodes: 0 NOP; 1 MOV Rd=Ra; 2 ADD Rd=Ra+Rb; 3 SUB Rd=Ra-Rb; 4 AND; 5 OR; 6 XOR; 7 NOT Rd=~Ra; 8 LDI Rd=IMM; 9 ADI Rd=Ra+IMM; A LD Rd=M[Ra]; B ST M[Ra]=Rb; C BRZ if Ra==0 PC=PC+IMM; D BRN if Ra[DW-1] PC=PC+IMM; E JMP PC=IMM[IMW-1:0]; F HLT.
- Arithmetic modulo 2^DW, carry/borrow discarded. Branch IMM is signed (DW bits); relative to incremented PC (address of branch + 1); result truncated to IMW bits, wraps.
- FSM: IDLE -(RUN)-> FETCH; FETCH: IR<=PMEM[PC], PC<=PC+1 (wraps), -> EXEC. EXEC: ALU/LDI/MOV write Rd, branch/jump update PC, ST writes memory, -> FETCH; LD issues read -> MEM; HLT -> HALT. MEM: Rd<=M[Ra], DATA_OUT<=same, -> FETCH. HALT stays until RST.
- Writes to R0 are ordinary (no hardwired zero). DA==AA legal: Ra read before write.
- PROG_WE honoured only in IDLE or HALT; ignored in FETCH/EXEC/MEM. Program and data memory are not cleared by reset.
- Reset: PC=0, IR=0, all registers 0, DATA_OUT=0, MEM_WE=0, STATE=IDLE, HALTED=0.

## Timing
- CPI: 2 cycles; LD 3 cycles; HLT reaches HALT 2 cycles after FETCH of it.
- Register/memory writes and PC redirect take effect on the EXEC (or MEM) edge; next FETCH sees them.
- MEM_WE high exactly during the EXEC cycle of ST.
- RST with any other event: reset wins; a store/register write in that cycle is suppressed.
- RUN ignored outside IDLE; RUN held high after reset gives FETCH one cycle after RST falls.
- Reset mid-instruction returns to IDLE next cycle; partial instruction has no effect.

## Configuration
- PARAM_COMPUTER_STEP_EN defined: STEP port exists; FETCH is entered from EXEC/MEM/IDLE-with-RUN as usual but FETCH only latches IR and advances when STEP is high that cycle, else holds (PC, IR unchanged). One instruction per STEP pulse.
- Undefined: no STEP port; FETCH never stalls.

## Test plan
- Reset: assert RST 2 cycles -> PC=0, IR=0, STATE=0, all DBG_REG reads 0, HALTED=0.
- Load {LDI R1,5; LDI R2,3; SUB R3,R1,R2; HLT}, pulse RUN -> R3=2, HALTED after 8 cycles of FETCH/EXEC, PC=4.
- Wrap: LDI R1,0xFF; ADI R1,R1,2 -> R1=0x01; NOT R2,R0 -> 0xFF.
- Memory: LDI R1,4; LDI R2,0xA5; ST [R1],R2; LD R3,[R1] -> MEM_WE one cycle, R3=0xA5, DATA_OUT=0xA5, LD takes 3 cycles.
- Branch: counter loop LDI R1,3; ADI R1,R1,-1; BRZ R1,+1; JMP 1; HLT -> HALT with R1=0; BRZ at PC 31 with IMM=+1 wraps PC to 1.
- PROG_WE during EXEC ignored (readback unchanged); RST during EXEC of ST -> memory word unchanged, STATE=IDLE.

Source files
------------

// File: rtl/param_computer_if.sv
// Program-load, run control and debug/status bundle of param_computer.
// The master side is the lab harness and the slave side is the CPU.
interface param_computer_if #(
  parameter int unsigned DW  = 8,
  parameter int unsigned RA  = 2,
  parameter int unsigned IMW = 5,
  parameter int unsigned IW  = 4 + 3 * RA + DW
);
  logic           RUN;
  logic           PROG_WE;
  logic [IMW-1:0] PROG_ADDR;
  logic [IW-1:0]  PROG_DATA;
  logic [RA-1:0]  DBG_SEL;
  logic [DW-1:0]  DBG_REG;
  logic [IMW-1:0] PC;
  logic [IW-1:0]  IR;
  logic [2:0]     STATE;
  logic           HALTED;
  logic [DW-1:0]  DATA_OUT;
  logic           MEM_WE;

  modport master (
    output RUN, PROG_WE, PROG_ADDR, PROG_DATA, DBG_SEL,
    input  DBG_REG, PC, IR, STATE, HALTED, DATA_OUT, MEM_WE
  );

  modport slave (
    input  RUN, PROG_WE, PROG_ADDR, PROG_DATA, DBG_SEL,
    output DBG_REG, PC, IR, STATE, HALTED, DATA_OUT, MEM_WE
  );
endinterface

// File: rtl/param_computer.sv
// Multicycle register computer: fetch/execute FSM, loadable program memory, data memory.
// Define PARAM_COMPUTER_STEP_EN to add the STEP port (one instruction per STEP pulse).
module param_computer #(
  parameter int unsigned DW  = 8,
  parameter int unsigned RA  = 2,
  parameter int unsigned IMW = 5,
  parameter int unsigned DMW = 4
) (
  input  logic CLK,
  input  logic RST,
`ifdef PARAM_COMPUTER_STEP_EN
  input  logic STEP,
`endif
  param_computer_if.slave bus
);
  localparam int unsigned NREG = 2 ** RA;
  localparam int unsigned IW   = 4 + 3 * RA + DW;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_MOV = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7,
    OP_LDI = 4'h8, OP_ADI = 4'h9, OP_LD  = 4'hA, OP_ST  = 4'hB,
    OP_BRZ = 4'hC, OP_BRN = 4'hD, OP_JMP = 4'hE, OP_HLT = 4'hF
  } op_t;

  state_t         state, state_next;
  logic [IMW-1:0] pc;
  logic [IW-1:0]  ir;
  logic [DW-1:0]  data_out;
  logic [DW-1:0]  regs [NREG];
  logic [IW-1:0]  pmem [2**IMW];
  logic [DW-1:0]  dmem [2**DMW];

  op_t            op;
  logic [RA-1:0]  da, aa, ba;
  logic [DW-1:0]  imm, ra_val, rb_val, alu, mem_rd;
  logic [DMW-1:0] maddr;
  logic [IMW-1:0] br_target;
  logic           step_ok, reg_we, mem_we, br_take;

`ifdef PARAM_COMPUTER_STEP_EN
  assign step_ok = STEP;
`else
  assign step_ok = 1'b1;
`endif

  assign op     = op_t'(ir[IW-1 -: 4]);
  assign da     = ir[DW+3*RA-1 -: RA];
  assign aa     = ir[DW+2*RA-1 -: RA];
  assign ba     = ir[DW+RA-1 -: RA];
  assign imm    = ir[DW-1:0];
  assign ra_val = regs[aa];
  assign rb_val = regs[ba];
  assign maddr  = ra_val[DMW-1:0];
  assign mem_rd = dmem[maddr];

  // Branch offset is sign-extended (or truncated) to PC width; PC already points past the branch.
  assign br_target = pc + IMW'($signed(imm));
  assign br_take   = ((op == OP_BRZ) && (ra_val == '0)) ||
                     ((op == OP_BRN) && ra_val[DW-1]);

  // A store coinciding with reset must not reach memory.
  assign mem_we = (state == S_EXEC) && (op == OP_ST) && !RST;

  always_comb begin
    alu    = '0;
    reg_we = 1'b0;
    case (op)
      OP_MOV: begin alu = ra_val;          reg_we = 1'b1; end
      OP_ADD: begin alu = ra_val + rb_val; reg_we = 1'b1; end
      OP_SUB: begin alu = ra_val - rb_val; reg_we = 1'b1; end
      OP_AND: begin alu = ra_val & rb_val; reg_we = 1'b1; end
      OP_OR:  begin alu = ra_val | rb_val; reg_we = 1'b1; end
      OP_XOR: begin alu = ra_val ^ rb_val; reg_we = 1'b1; end
      OP_NOT: begin alu = ~ra_val;         reg_we = 1'b1; end
      OP_LDI: begin alu = imm;             reg_we = 1'b1; end
      OP_ADI: begin alu = ra_val + imm;    reg_we = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.RUN) state_next = S_FETCH;
      S_FETCH: if (step_ok) state_next = S_EXEC;
      S_EXEC: begin
        if (op == OP_LD)       state_next = S_MEM;
        else if (op == OP_HLT) state_next = S_HALT;
        else                   state_next = S_FETCH;
      end
      S_MEM:   state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc       <= '0;
      ir       <= '0;
      data_out <= '0;
      for (int unsigned i = 0; i < NREG; i++) regs[RA'(i)] <= '0;
    end else begin
      case (state)
        S_FETCH: if (step_ok) begin
          ir <= pmem[pc];
          pc <= pc + IMW'(1);
        end
        S_EXEC: begin
          if (reg_we) regs[da] <= alu;
          if (br_take)            pc <= br_target;
          else if (op == OP_JMP)  pc <= IMW'(imm);
        end
        S_MEM: begin
          regs[da] <= mem_rd;
          data_out <= mem_rd;
        end
        default: ;
      endcase
    end
  end

  // Memories are deliberately left out of reset so a loaded program survives it.
  always_ff @(posedge CLK) begin
    if (mem_we) dmem[maddr] <= rb_val;
    if (bus.PROG_WE && ((state == S_IDLE) || (state == S_HALT)))
      pmem[bus.PROG_ADDR] <= bus.PROG_DATA;
  end

  assign bus.DBG_REG  = regs[bus.DBG_SEL];
  assign bus.PC       = pc;
  assign bus.IR       = ir;
  assign bus.STATE    = state;
  assign bus.HALTED   = (state == S_HALT);
  assign bus.DATA_OUT = data_out;
  assign bus.MEM_WE   = mem_we;
endmodule

// File: tb/tb_param_computer.sv
// Scoreboard bench for param_computer: an ISA-level interpreter predicts the end state of
// each program; a monitor compares when the CPU halts or when a snapshot is requested.
module tb_param_computer;
  localparam int DW = 8, RA = 2, IMW = 5, DMW = 4, IW = 18;
  localparam int K_REG = 0, K_PC = 1, K_DOUT = 2, K_CYC = 3, K_ST = 4,
                 K_STATE = 5, K_IR = 6, K_HALT = 7, K_MEMWE = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
`ifdef PARAM_COMPUTER_STEP_EN
  logic STEP = 1'b1;
`endif
  always #5 CLK = ~CLK;

  param_computer_if #(.DW(DW), .RA(RA), .IMW(IMW)) bus ();

  param_computer #(.DW(DW), .RA(RA), .IMW(IMW), .DMW(DMW)) dut (
    .CLK(CLK),
    .RST(RST),
`ifdef PARAM_COMPUTER_STEP_EN
    .STEP(STEP),
`endif
    .bus(bus)
  );

  typedef struct {
    int    kind;
    int    sel;
    int    val;
    string name;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0, passes = 0;
  int          req = 0, served = 0, req_kind = 0;
  logic [17:0] prog [32];

  // Reference model state
  int m_dm[16], m_dmt[16], m_r[4];
  int m_pc, m_cyc, m_st, m_dout;
  bit m_halt;

  function automatic logic [17:0] enc(int op, int d, int a, int b, int imm);
    return {4'(op), 2'(d), 2'(a), 2'(b), 8'(imm)};
  endfunction

  function automatic void run_model();
    int ins, op, d, a, b, imm, simm, av, bv;
    m_dmt = m_dm;
    m_r = '{default: 0};
    m_pc = 0; m_cyc = 0; m_st = 0; m_dout = 0; m_halt = 0;
    for (int n = 0; n < 150 && !m_halt; n++) begin
      ins  = int'(prog[m_pc]);
      m_pc = (m_pc + 1) % 32;
      m_cyc += 2;
      op = (ins >> 14) & 15; d = (ins >> 12) & 3; a = (ins >> 10) & 3;
      b = (ins >> 8) & 3;    imm = ins & 255;
      simm = (imm >= 128) ? imm - 256 : imm;
      av = m_r[a]; bv = m_r[b];
      case (op)
        1:  m_r[d] = av;
        2:  m_r[d] = (av + bv) % 256;
        3:  m_r[d] = (av - bv + 256) % 256;
        4:  m_r[d] = av & bv;
        5:  m_r[d] = av | bv;
        6:  m_r[d] = av ^ bv;
        7:  m_r[d] = 255 - av;
        8:  m_r[d] = imm;
        9:  m_r[d] = (av + imm) % 256;
        10: begin m_cyc++; m_r[d] = m_dmt[av % 16]; m_dout = m_r[d]; end
        11: begin m_dmt[av % 16] = bv; m_st++; end
        12: if (av == 0)   m_pc = (((m_pc + simm) % 32) + 32) % 32;
        13: if (av >= 128) m_pc = (((m_pc + simm) % 32) + 32) % 32;
        14: m_pc = imm % 32;
        15: m_halt = 1;
        default: ;
      endcase
    end
  endfunction

  task automatic push(int kind, int sel, int val, string name);
    exp_t e;
    e.kind = kind; e.sel = sel; e.val = val; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic push_run_exp(string tag);
    for (int i = 0; i < 4; i++) push(K_REG, i, m_r[i], $sformatf("%s R%0d", tag, i));
    push(K_PC,    0, m_pc,   {tag, " PC"});
    push(K_IR,    0, int'(prog[(m_pc + 31) % 32]), {tag, " IR"});
    push(K_DOUT,  0, m_dout, {tag, " DATA_OUT"});
    push(K_CYC,   0, m_cyc,  {tag, " cycles"});
    push(K_ST,    0, m_st,   {tag, " MEM_WE cycles"});
    push(K_HALT,  0, 1,      {tag, " HALTED"});
    push(K_STATE, 0, 4,      {tag, " STATE"});
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog[i] = '0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 32; i++) begin
      bus.PROG_WE   = 1'b1;
      bus.PROG_ADDR = IMW'(i);
      bus.PROG_DATA = prog[i];
      @(negedge CLK);
    end
    bus.PROG_WE = 1'b0;
  endtask

  task automatic wait_served(int target);
    while (served != target) @(negedge CLK);
  endtask

  task automatic snap();
    req_kind = 0;
    req++;
    wait_served(req);
  endtask

  // Expectations from hard constants must be pushed by the caller before this.
  task automatic run_program(string tag, bit poke, logic [17:0] poke_word);
    int target;
    do_reset();
    load_prog();
    run_model();
    m_dm = m_dmt;
    push_run_exp(tag);
    req_kind = 1;
    req++;
    target = req;
    bus.RUN = 1'b1;
    @(negedge CLK);
    bus.RUN = 1'b0;
    if (poke) begin
      for (int k = 0; k < 10 && bus.STATE != 3'd2; k++) @(negedge CLK);
      bus.PROG_WE   = 1'b1;
      bus.PROG_ADDR = 5'd3;
      bus.PROG_DATA = poke_word;
      @(negedge CLK);
      bus.PROG_WE = 1'b0;
    end
    wait_served(target);
  endtask

  initial begin : monitor
    int   cyc, stores, waitc, got;
    bit   timed_out;
    exp_t e;
    cyc = 0; stores = 0; waitc = 0;
    bus.DBG_SEL = '0;
    forever begin
      @(negedge CLK);
      if (bus.STATE == 3'd0) begin
        cyc = 0; stores = 0;
      end else if (bus.STATE inside {3'd1, 3'd2, 3'd3}) begin
        cyc++;
      end
      if (bus.MEM_WE) stores++;
      waitc     = (req != served) ? waitc + 1 : 0;
      timed_out = (waitc > 4000);
      if ((req != served) && (req_kind == 0 || bus.HALTED || timed_out)) begin
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          got = -1;
          if (!timed_out) begin
            case (e.kind)
              K_REG:   begin bus.DBG_SEL = 2'(e.sel); #1; got = int'(bus.DBG_REG); end
              K_PC:    got = int'(bus.PC);
              K_DOUT:  got = int'(bus.DATA_OUT);
              K_CYC:   got = cyc;
              K_ST:    got = stores;
              K_STATE: got = int'(bus.STATE);
              K_IR:    got = int'(bus.IR);
              K_HALT:  got = int'(bus.HALTED);
              K_MEMWE: got = int'(bus.MEM_WE);
              default: got = -1;
            endcase
          end
          checks++;
          if (timed_out)
            $display("FAIL %s: no halt within cycle budget, expected %0d", e.name, e.val);
          else if (got == e.val)
            passes++;
          else
            $display("FAIL %s: got %0d, expected %0d", e.name, got, e.val);
        end
        served = req;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin : stimulus
    logic [17:0] w;
    bus.RUN = 1'b0; bus.PROG_WE = 1'b0; bus.PROG_ADDR = '0; bus.PROG_DATA = '0;
    m_dm = '{default: 0};

    // Reset state
    do_reset();
    checks++;
    if (bus.STATE == 3'd0 && bus.HALTED == 1'b0 && bus.PC == '0) passes++;
    else $display("FAIL reset direct: STATE=%0d HALTED=%0d PC=%0d, expected 0/0/0",
                  bus.STATE, bus.HALTED, bus.PC);
    push(K_STATE, 0, 0, "reset STATE"); push(K_PC, 0, 0, "reset PC");
    push(K_IR, 0, 0, "reset IR");       push(K_HALT, 0, 0, "reset HALTED");
    push(K_DOUT, 0, 0, "reset DATA_OUT"); push(K_MEMWE, 0, 0, "reset MEM_WE");
    for (int i = 0; i < 4; i++) push(K_REG, i, 0, $sformatf("reset R%0d", i));
    snap();

    // Fill every data word (dm[k] = 0x30 + 7k) with a counted loop
    clear_prog();
    prog[0] = enc(8, 1, 0, 0, 0);    prog[1] = enc(8, 2, 0, 0, 8'h30);
    prog[2] = enc(11, 0, 1, 2, 0);   prog[3] = enc(9, 1, 1, 0, 1);
    prog[4] = enc(9, 2, 2, 0, 7);    prog[5] = enc(9, 3, 1, 0, 240);
    prog[6] = enc(12, 0, 3, 0, 1);   prog[7] = enc(14, 0, 0, 0, 2);
    prog[8] = enc(15, 0, 0, 0, 0);
    push(K_ST, 0, 16, "fill stores"); push(K_PC, 0, 9, "fill PC");
    run_program("fill", 0, '0);

    // SUB
    clear_prog();
    prog[0] = enc(8, 1, 0, 0, 5); prog[1] = enc(8, 2, 0, 0, 3);
    prog[2] = enc(3, 3, 1, 2, 0); prog[3] = enc(15, 0, 0, 0, 0);
    push(K_REG, 3, 2, "sub R3 const"); push(K_CYC, 0, 8, "sub cycles const");
    push(K_PC, 0, 4, "sub PC const");
    run_program("sub", 0, '0);

    // Modulo wrap and NOT
    clear_prog();
    prog[0] = enc(8, 1, 0, 0, 8'hFF); prog[1] = enc(9, 1, 1, 0, 2);
    prog[2] = enc(7, 2, 0, 0, 0);     prog[3] = enc(15, 0, 0, 0, 0);
    push(K_REG, 1, 1, "wrap R1 const"); push(K_REG, 2, 255, "wrap R2 const");
    run_program("wrap", 0, '0);

    // Store then load
    clear_prog();
    prog[0] = enc(8, 1, 0, 0, 4);  prog[1] = enc(8, 2, 0, 0, 8'hA5);
    prog[2] = enc(11, 0, 1, 2, 0); prog[3] = enc(10, 3, 1, 0, 0);
    prog[4] = enc(15, 0, 0, 0, 0);
    push(K_REG, 3, 8'hA5, "mem R3 const"); push(K_DOUT, 0, 8'hA5, "mem DATA_OUT const");
    push(K_ST, 0, 1, "mem MEM_WE const");  push(K_CYC, 0, 11, "mem cycles const");
    run_program("mem", 0, '0);

    // Counter loop
    clear_prog();
    prog[0] = enc(8, 1, 0, 0, 3);  prog[1] = enc(9, 1, 1, 0, 255);
    prog[2] = enc(12, 0, 1, 0, 1); prog[3] = enc(14, 0, 0, 0, 1);
    prog[4] = enc(15, 0, 0, 0, 0);
    push(K_REG, 1, 0, "loop R1 const"); push(K_PC, 0, 5, "loop PC const");
    run_program("loop", 0, '0);

    // Branch at the last program address wraps the PC
    clear_prog();
    prog[0]  = enc(14, 0, 0, 0, 31); prog[31] = enc(12, 0, 0, 0, 1);
    prog[1]  = enc(8, 1, 0, 0, 8'h77); prog[2] = enc(15, 0, 0, 0, 0);
    push(K_REG, 1, 8'h77, "brwrap R1 const"); push(K_PC, 0, 3, "brwrap PC const");
    run_program("brwrap", 0, '0);

    // Program write while executing is ignored
    clear_prog();
    prog[3] = enc(8, 2, 0, 0, 8'h11); prog[4] = enc(15, 0, 0, 0, 0);
    push(K_REG, 2, 8'h11, "progwe R2 const");
    run_program("progwe", 1, enc(8, 2, 0, 0, 8'h99));

    // Reset during EXEC of a store suppresses the store
    clear_prog();
    prog[0] = enc(8, 1, 0, 0, 9);  prog[1] = enc(8, 2, 0, 0, 8'h5A);
    prog[2] = enc(11, 0, 1, 2, 0); prog[3] = enc(15, 0, 0, 0, 0);
    do_reset();
    load_prog();
    bus.RUN = 1'b1;
    @(negedge CLK);
    bus.RUN = 1'b0;
    w = enc(11, 0, 1, 2, 0);
    for (int k = 0; k < 20 && !(bus.STATE == 3'd2 && bus.IR == w); k++) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    push(K_STATE, 0, 0, "rstst STATE"); push(K_PC, 0, 0, "rstst PC");
    push(K_HALT, 0, 0, "rstst HALTED");
    snap();
    clear_prog();
    prog[0] = enc(8, 1, 0, 0, 9); prog[1] = enc(10, 3, 1, 0, 0); prog[2] = enc(15, 0, 0, 0, 0);
    push(K_REG, 3, 8'h6F, "rstst readback const");
    run_program("rstst", 0, '0);

    // Random programs
    for (int t = 0; t < 20; t++) begin
      do begin
        for (int i = 0; i < 32; i++)
          prog[i] = enc(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 255)));
        run_model();
      end while (!m_halt);
      run_program($sformatf("rand%0d", t), 0, '0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
